dds_pbk_sequencer: RTL

Sequencer for one DDS channel's parallel modulation port (tx_en, pf[1:0], pdat[15:0]) and I/O-update strobe. It buffers a list of timed entries (type, data, hold count, last flag) in an internal FIFO. On command it plays the entries back cycle-accurately, then issues a fixed-width io_upd pulse at the end of the segment. Outputs feed the aligned-bus stage of the DDS function module, one instance per channel.

---
 rtl/dds_pbk_sequencer_if.sv | 14 +
 rtl/dds_pbk_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dds_pbk_sequencer_if.sv
// Entry write channel of the DDS parallel-port sequencer: one timed entry per valid/ready handshake.
interface dds_pbk_sequencer_if #(
  parameter int CW = 16
);
  logic          in_vld;
  logic          in_rdy;
  logic [1:0]    in_pf;
  logic [15:0]   in_dat;
  logic [CW-1:0] in_hold;
  logic          in_last;

  modport master (output in_vld, in_pf, in_dat, in_hold, in_last, input in_rdy);
  modport slave  (input in_vld, in_pf, in_dat, in_hold, in_last, output in_rdy);
endinterface

// File: rtl/dds_pbk_sequencer.sv
// Plays a FIFO of timed entries onto one DDS channel's parallel port, then strobes io_upd
// for UPD_W cycles at the end of each segment.
module dds_pbk_sequencer #(
  parameter int DEPTH = 16,
  parameter int CW    = 16,
  parameter int UPD_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dds_pbk_sequencer_if.slave     in_if,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_en,
  output logic [1:0]             pf,
  output logic [15:0]            pdat,
  output logic                   io_upd
);
  localparam int AW = $clog2(DEPTH);
  localparam int UW = (UPD_W > 1) ? $clog2(UPD_W) : 1;
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [UW-1:0] UPD_LOAD = UW'(UPD_W - 1);

  typedef struct packed {
    logic [1:0]    pf;
    logic [15:0]   dat;
    logic [CW-1:0] hold;
    logic          last;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  logic [CW-1:0] hold_cnt_r;
  logic [UW-1:0] upd_cnt_r;
  logic          cur_last_r;
  logic          busy_r;
  logic          underrun_r;
  logic          tx_en_r;
  logic          io_upd_r;
  logic [1:0]    pf_r;
  logic [15:0]   pdat_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  entry_t        head_s;
  entry_t        wr_entry_s;

  // FIFO flags, write/read decisions; a pop is requested only when playback consumes the head
  always_comb begin
    full_s          = (count_r == FULL_LVL);
    empty_s         = (count_r == {(AW+1){1'b0}});
    head_s          = mem_r[rd_ptr_r];
    wr_entry_s.pf   = in_if.in_pf;
    wr_entry_s.dat  = in_if.in_dat;
    wr_entry_s.hold = in_if.in_hold;
    wr_entry_s.last = in_if.in_last;
    push_s          = in_if.in_vld && !full_s && !abort;
    pop_s           = 1'b0;
    if (abort) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: pop_s = start && !empty_s;
        ST_PLAY: pop_s = (hold_cnt_r == {CW{1'b0}}) && !cur_last_r && !empty_s;
        default: pop_s = 1'b0;
      endcase
    end
  end

  assign in_if.in_rdy = !full_s;

  // Entry storage; occupancy is tracked by count_r so the array itself needs no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Playback FSM with FIFO pointers and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      state_r    <= ST_IDLE;
      hold_cnt_r <= {CW{1'b0}};
      upd_cnt_r  <= {UW{1'b0}};
      cur_last_r <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
      tx_en_r    <= 1'b0;
      io_upd_r   <= 1'b0;
      pf_r       <= 2'd0;
      pdat_r     <= 16'd0;
    end else if (abort) begin
      // Flush and stop; pf/pdat and the sticky underrun flag are left as they were
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      state_r    <= ST_IDLE;
      hold_cnt_r <= {CW{1'b0}};
      upd_cnt_r  <= {UW{1'b0}};
      busy_r     <= 1'b0;
      tx_en_r    <= 1'b0;
      io_upd_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase

      case (state_r)
        ST_IDLE: begin
          tx_en_r  <= 1'b0;
          io_upd_r <= 1'b0;
          if (start) begin
            if (!empty_s) begin
              pf_r       <= head_s.pf;
              pdat_r     <= head_s.dat;
              hold_cnt_r <= head_s.hold;
              cur_last_r <= head_s.last;
              tx_en_r    <= 1'b1;
              underrun_r <= 1'b0;
              busy_r     <= 1'b1;
              state_r    <= ST_PLAY;
            end else begin
              underrun_r <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (hold_cnt_r != {CW{1'b0}}) begin
            hold_cnt_r <= hold_cnt_r - CW'(1'b1);
          end else if (cur_last_r) begin
            tx_en_r   <= 1'b0;
            io_upd_r  <= 1'b1;
            upd_cnt_r <= UPD_LOAD;
            state_r   <= ST_UPD;
          end else if (!empty_s) begin
            // Next entry follows with no gap cycle
            pf_r       <= head_s.pf;
            pdat_r     <= head_s.dat;
            hold_cnt_r <= head_s.hold;
            cur_last_r <= head_s.last;
          end else begin
            tx_en_r    <= 1'b0;
            underrun_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_UPD: begin
          if (upd_cnt_r == {UW{1'b0}}) begin
            io_upd_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            upd_cnt_r <= upd_cnt_r - UW'(1'b1);
          end
        end
        default: begin
          tx_en_r  <= 1'b0;
          io_upd_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign underrun = underrun_r;
  assign level    = count_r;
  assign tx_en    = tx_en_r;
  assign pf       = pf_r;
  assign pdat     = pdat_r;
  assign io_upd   = io_upd_r;

endmodule
